alu_share_ctrl: RTL

ALU_SHARE_CTRL -- requirements
Module: alu_share_ctrl

---
 rtl/alu_share_ctrl.sv | 130 +++++++++++++
 1 files changed

// File: rtl/alu_share_ctrl.sv
// Two-requester front end for one shared ALU: round-robin grant, operand capture,
// fixed-latency MUL hold and a held response until the consumer takes it.
module alu_share_ctrl #(
   parameter int MUL_LAT = 3,
   parameter int XLEN    = 32
) (
   input  logic              clk_i,
   input  logic              rst_i,
   input  logic [1:0]        req_valid_i,
   output logic [1:0]        req_ready_o,
   input  logic [5:0]        req_ctrl_i,
   input  logic [2*XLEN-1:0] req_a_i,
   input  logic [2*XLEN-1:0] req_b_i,
   input  logic              flush_i,
   output logic [2:0]        alu_ctrl_o,
   output logic [XLEN-1:0]   alu_a_o,
   output logic [XLEN-1:0]   alu_b_o,
   output logic              alu_start_o,
   input  logic [XLEN-1:0]   alu_result_i,
   output logic              rsp_valid_o,
   input  logic              rsp_ready_i,
   output logic              rsp_id_o,
   output logic [XLEN-1:0]   rsp_data_o,
   output logic              busy_o
);

   localparam logic [2:0] CTRL_ADD = 3'b001;
   localparam logic [2:0] CTRL_MUL = 3'b110;

   typedef enum logic [1:0] {S_IDLE, S_EXEC, S_WAIT, S_RESP} state_t;

   state_t            state_q, state_d;
   logic [2:0]        ctrl_q, ctrl_d;
   logic [XLEN-1:0]   a_q, a_d, b_q, b_d, data_q, data_d;
   logic              id_q, id_d, last_q, last_d;
   logic [3:0]        cnt_q, cnt_d;
   logic              gid;
   logic [2:0]        raw_ctrl;

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         state_q <= S_IDLE;
         ctrl_q  <= CTRL_ADD;
         a_q     <= '0;
         b_q     <= '0;
         data_q  <= '0;
         id_q    <= 1'b0;
         last_q  <= 1'b1;
         cnt_q   <= '0;
      end else begin
         state_q <= state_d;
         ctrl_q  <= ctrl_d;
         a_q     <= a_d;
         b_q     <= b_d;
         data_q  <= data_d;
         id_q    <= id_d;
         last_q  <= last_d;
         cnt_q   <= cnt_d;
      end
   end

   always_comb begin
      state_d     = state_q;
      ctrl_d      = ctrl_q;
      a_d         = a_q;
      b_d         = b_q;
      data_d      = data_q;
      id_d        = id_q;
      last_d      = last_q;
      cnt_d       = cnt_q;
      req_ready_o = 2'b00;
      alu_start_o = 1'b0;
      // Tie goes to whoever was not granted last; a lone request always wins.
      gid         = (req_valid_i == 2'b10) ? 1'b1 :
                    (req_valid_i == 2'b11) ? ~last_q : 1'b0;
      raw_ctrl    = gid ? req_ctrl_i[5:3] : req_ctrl_i[2:0];
      case (state_q)
         S_IDLE: begin
            if (!flush_i && (req_valid_i != 2'b00)) begin
               req_ready_o = gid ? 2'b10 : 2'b01;
               case (raw_ctrl)
                  3'b001, 3'b010, 3'b011, 3'b100, 3'b110: ctrl_d = raw_ctrl;
                  default:                                ctrl_d = CTRL_ADD;
               endcase
               a_d     = gid ? req_a_i[2*XLEN-1:XLEN] : req_a_i[XLEN-1:0];
               b_d     = gid ? req_b_i[2*XLEN-1:XLEN] : req_b_i[XLEN-1:0];
               id_d    = gid;
               last_d  = gid;
               state_d = S_EXEC;
            end
         end
         S_EXEC: begin
            alu_start_o = 1'b1;
            if (flush_i) begin
               state_d = S_IDLE;
            end else if (ctrl_q == CTRL_MUL) begin
               cnt_d   = 4'(MUL_LAT - 2);
               state_d = S_WAIT;
            end else begin
               data_d  = alu_result_i;
               state_d = S_RESP;
            end
         end
         S_WAIT: begin
            if (flush_i) begin
               state_d = S_IDLE;
            end else if (cnt_q == 4'd0) begin
               data_d  = alu_result_i;
               state_d = S_RESP;
            end else begin
               cnt_d = cnt_q - 4'd1;
            end
         end
         S_RESP: begin
            if (flush_i || rsp_ready_i) state_d = S_IDLE;
         end
         default: state_d = S_IDLE;
      endcase
   end

   assign alu_ctrl_o  = ctrl_q;
   assign alu_a_o     = a_q;
   assign alu_b_o     = b_q;
   // A flush in RESP withdraws the response in the same cycle so no handshake can slip through.
   assign rsp_valid_o = (state_q == S_RESP) && !flush_i;
   assign rsp_id_o    = id_q;
   assign rsp_data_o  = data_q;
   assign busy_o      = (state_q != S_IDLE);

endmodule
